// File: rtl/pm_serial_loader.sv
// Boot loader: receives a length-prefixed, checksummed program image over
// a UART line, writes it into program memory and then releases the core.
//
// Ports:
//   clk, reset   system clock; asynchronous active-high reset
//   rx           UART serial input (8N1, LSB first, idle high, async)
//   pm_wr_addr   program memory write address
//   pm_wr_data   program memory write data
//   pm_wren      one-cycle program memory write strobe
//   micro_reset  core reset (1 = hold core)
//   load_done    image accepted, core released
//   error        last load failed (checksum or framing)
module pm_serial_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] pm_wr_addr,
    output logic [7:0] pm_wr_data,
    output logic       pm_wren,
    output logic       micro_reset,
    output logic       load_done,
    output logic       error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HALF_M1 = cnt_t'(CLKS_PER_BIT / 2 - 1);
    localparam cnt_t FULL_M1 = cnt_t'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // rx synchronizer (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic rx_s1_q;
    logic rx_s2_q;
    logic rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_s = rx_s2_q;

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    rx_state_t  rxs_q, rxs_d;
    cnt_t       tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       armed_q, armed_d;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] rx_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxs_q   <= R_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b1;
        end else begin
            rxs_q   <= rxs_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        rxs_d      = rxs_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rxs_q)
            R_IDLE: begin
                tick_d = '0;
                // After a frame the line must be seen high before a new
                // falling edge counts, so a held-low break is one error.
                if (!armed_q) begin
                    armed_d = rx_s;
                end else if (!rx_s) begin
                    rxs_d = R_START;
                end
            end
            R_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d = '0;
                    if (rx_s) begin
                        rxs_d = R_IDLE;
                    end else begin
                        rxs_d = R_DATA;
                        bit_d = '0;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            R_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        rxs_d = R_STOP;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            R_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    rxs_d   = R_IDLE;
                    armed_d = rx_s;
                    if (rx_s) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: rxs_d = R_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_RUN,
        S_ERR
    } ld_state_t;

    ld_state_t  st_q, st_d;
    logic [8:0] len_q, len_d;
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wren_q, wren_d;
    logic       mrst_q, mrst_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= S_LEN;
            len_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            mrst_q <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wren_q <= wren_d;
            mrst_q <= mrst_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        data_d = data_q;
        wren_d = 1'b0;
        mrst_d = mrst_q;
        done_d = done_q;
        err_d  = err_q;
        // Address advances the cycle after each write strobe.
        addr_d = wren_q ? addr_q + 8'd1 : addr_q;
        case (st_q)
            S_LEN, S_ERR: begin
                if (byte_valid) begin
                    len_d  = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    cnt_d  = '0;
                    sum_d  = '0;
                    addr_d = '0;
                    err_d  = 1'b0;
                    st_d   = S_DATA;
                end else if (frame_err) begin
                    err_d = 1'b1;
                    st_d  = S_ERR;
                end
            end
            S_DATA: begin
                if (byte_valid) begin
                    data_d = rx_byte;
                    wren_d = 1'b1;
                    sum_d  = sum_q + rx_byte;
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q + 9'd1 == len_q) begin
                        st_d = S_SUM;
                    end
                end else if (frame_err) begin
                    err_d = 1'b1;
                    st_d  = S_ERR;
                end
            end
            S_SUM: begin
                if (byte_valid) begin
                    if (rx_byte == sum_q) begin
                        st_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                        st_d  = S_ERR;
                    end
                end else if (frame_err) begin
                    err_d = 1'b1;
                    st_d  = S_ERR;
                end
            end
            S_RUN: begin
                // Terminal until reset; release follows state entry.
                mrst_d = 1'b0;
                done_d = 1'b1;
            end
            default: st_d = S_LEN;
        endcase
    end

    assign pm_wr_addr  = addr_q;
    assign pm_wr_data  = data_q;
    assign pm_wren     = wren_q;
    assign micro_reset = mrst_q;
    assign load_done   = done_q;
    assign error       = err_q;

endmodule

// File: doc/pm_serial_loader.md
Name: pm_serial_loader

Overview:
Boot-time loader sitting upstream of the micro core. It receives a program image over a UART line and writes it byte-by-byte into the program memory write port. It holds the core's reset input asserted until a complete, checksum-valid image is stored, then releases the core to run from address 0.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be even and at least 4.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high; clears all state.
rx  input  1  UART serial input, 8N1, LSB first, idle high, asynchronous to clk.
pm_wr_addr  output  8  program memory write address.
pm_wr_data  output  8  program memory write data.
pm_wren  output  1  one-cycle program memory write strobe.
micro_reset  output  1  drives the core's reset input; 1 means hold the core.
load_done  output  1  image accepted; core released.
error  output  1  last load failed (checksum or framing).

Behaviour:
- Reset values: pm_wr_addr=0x00, pm_wr_data=0x00, pm_wren=0, micro_reset=1, load_done=0, error=0. Receiver is idle and the FSM is in S_LEN.
- rx path: 2-flop synchronizer, initialised to 1 on reset. All rx references below mean the synchronized rx.
- Byte receiver:
  - In idle, rx=0 starts a frame. Wait CLKS_PER_BIT/2 clocks and resample.
  - If rx is 1 at that sample: false start, return to idle, no byte.
  - Otherwise sample 8 data bits, one every CLKS_PER_BIT clocks, LSB first, then the stop bit.
  - Stop bit = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop bit = 0: frame_err pulses for 1 cycle.
  - Receiver returns to idle the cycle after the stop sample. It does not re-arm until rx has been seen high.
- Loader FSM:
  - S_LEN: the next byte_valid latches len (0x00 means 256). Clear sum and pm_wr_addr to 0, clear error. Go to S_DATA.
  - S_DATA: each byte_valid drives pm_wr_data=byte and pm_wren=1 in the same cycle, at the current pm_wr_addr.
    - sum <= sum+byte (mod 256). pm_wr_addr increments by 1 (mod 256) in the cycle after the write.
    - After the len-th byte go to S_SUM.
    - For len=256, pm_wr_addr wraps to 0x00 after the last write.
  - S_SUM: on byte_valid, byte==sum goes to S_RUN; otherwise go to S_ERR.
  - S_RUN: micro_reset=0 and load_done=1, both registered and changing the cycle after entry. rx is ignored and S_RUN holds until reset.
  - S_ERR: error=1, micro_reset stays 1. The next byte_valid is treated as a new length byte: same actions as S_LEN, with error cleared.
- Framing errors: a frame_err in S_LEN, S_DATA or S_SUM goes to S_ERR and discards the partial load. In S_RUN it is ignored.
- pm_wren: only ever a single-cycle pulse, and never asserted outside S_DATA.
- Output timing: all outputs are registered; no combinational path from rx to any output.
- Reset mid-operation: any FSM state returns immediately to reset values. Program memory already written is not erased.

Test Plan:
- Good load (CLKS_PER_BIT=16): send 0x03, 0xC1, 0x23, 0x45, 0x29.
  - Expect 3 pm_wren pulses: (0x00,0xC1), (0x01,0x23), (0x02,0x45).
  - After the checksum frame, micro_reset falls to 0 and load_done=1, error=0.
  - Further rx bytes cause no writes.
- Bad checksum: send 0x02, 0x10, 0x20, 0x31.
  - Expect 2 writes, then error=1 and micro_reset=1.
  - Then send 0x01, 0x7F, 0x7F: error clears on the 0x01 and 0x7F is written at 0x00; load_done=1.
- Framing error: send 0x02, then 0xAA with stop bit held 0.
  - Expect no write for 0xAA, error=1, micro_reset=1.
- False start: rx low for 4 clocks, then high.
  - Expect no byte_valid, no write, FSM stays in S_LEN.
  - A following valid 0x01, 0x55, 0x55 loads normally.
- Wrap: len=0x00, then 256 bytes of value k at index k, then checksum 0x80.
  - Expect writes at addresses 0x00..0xFF, then pm_wr_addr=0x00 and load_done=1.
- Async reset mid-load: assert reset during the 2nd data byte of a len=4 load.
  - Outputs return to reset values immediately, without waiting for a clk edge.
  - A fresh load starting at len=0x01 writes address 0x00.
